// File: rtl/display_pkg.sv
// Shared types and defaults for the display scan-out stage: pixel layout,
// scan FSM states and the frame geometry used when no override is given.
package display_pkg;

  localparam int RGB_W          = 8;
  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_H_ACTIVE   = 100;
  localparam int DEF_V_ACTIVE   = 100;
  localparam int DEF_H_FP       = 4;
  localparam int DEF_H_SW       = 8;
  localparam int DEF_H_BP       = 8;
  localparam int DEF_V_FP       = 1;
  localparam int DEF_V_SW       = 2;
  localparam int DEF_V_BP       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } pixel_t;

  // Forces the colour to black whenever the display is not in its data window.
  function automatic pixel_t gate_pixel(input logic en, input pixel_t px);
    pixel_t res;
    if (en) res = px;
    else    res = '0;
    return res;
  endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// Raster timing for one frame: h/v counters that run only while enabled,
// plus the stage-0 active window, raw sync windows and end-of-frame marker.
module disp_timing_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SW     = DEF_H_SW,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SW     = DEF_V_SW,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic active_o,
  output logic hsync_raw_o,
  output logic vsync_raw_o,
  output logic eof_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SW + V_BP;
  // One extra count of headroom so the sync-window end never aliases to 0.
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SW);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SW);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;

  // Counters sit at 0 whenever not scanning so the first scan clock is h=v=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!run_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1'b1);
    end else begin
      h_q <= h_q + HW'(1'b1);
    end
  end

  assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_raw_o = (h_q >= HS_START) && (h_q < HS_END);
  assign vsync_raw_o = (v_q >= VS_START) && (v_q < VS_END);
  assign eof_o       = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Frame-buffer scan-out: waits for a full frame, reads it in raster order and
// drives RGB with DE/HSYNC/VSYNC aligned to the one-clock read latency.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SW     = DEF_H_SW,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SW     = DEF_V_SW,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              buf_full,
  input  logic [RGB_W-1:0]  r_in,
  input  logic [RGB_W-1:0]  g_in,
  input  logic [RGB_W-1:0]  b_in,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_empty,
  output logic [RGB_W-1:0]  pix_r,
  output logic [RGB_W-1:0]  pix_g,
  output logic [RGB_W-1:0]  pix_b,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_done
);

  scan_state_e       state_q;
  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic              buf_empty_q;
  logic              de_q;
  logic              hsync_q;
  logic              vsync_q;
  logic              frame_done_q;

  logic   active_s;
  logic   hsync_raw_s;
  logic   vsync_raw_s;
  logic   eof_s;
  logic   scan_s;
  pixel_t pix_s;

  assign scan_s = (state_q == SCAN);

  disp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_FP     (H_FP),
    .H_SW     (H_SW),
    .H_BP     (H_BP),
    .V_FP     (V_FP),
    .V_SW     (V_SW),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (reset),
    .run_i       (scan_s),
    .active_o    (active_s),
    .hsync_raw_o (hsync_raw_s),
    .vsync_raw_o (vsync_raw_s),
    .eof_o       (eof_s)
  );

  assign buf_re = scan_s && active_s;

  // Scan FSM, read-address counter and the one-stage sync/DE pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      full_q       <= 1'b0;
      addr_q       <= '0;
      buf_empty_q  <= 1'b1;
      de_q         <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      full_q       <= buf_full;
      de_q         <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (buf_full && !full_q) begin
            state_q     <= SCAN;
            buf_empty_q <= 1'b0;
          end
        end
        SCAN: begin
          de_q    <= active_s;
          hsync_q <= ~hsync_raw_s;
          vsync_q <= ~vsync_raw_s;
          if (buf_re) addr_q <= addr_q + ADDR_W'(1'b1);
          if (eof_s) begin
            state_q      <= DONE;
            buf_empty_q  <= 1'b1;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          addr_q  <= '0;
        end
        default: begin
          state_q     <= IDLE;
          addr_q      <= '0;
          buf_empty_q <= 1'b1;
        end
      endcase
    end
  end

  // Read data returns one clock after buf_re, i.e. in the clock de_q is high.
  always_comb begin
    pix_s = gate_pixel(de_q, '{r: r_in, g: g_in, b: b_in});
  end

  assign buf_addr   = addr_q;
  assign buf_empty  = buf_empty_q;
  assign pix_r      = pix_s.r;
  assign pix_g      = pix_s.g;
  assign pix_b      = pix_s.b;
  assign de         = de_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl on a 4x3 frame with 1-clock/1-line porches.
module tb_display_scan_ctrl;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          buf_full;
  logic [7:0]    r_in, g_in, b_in;
  logic          buf_re;
  logic [AW-1:0] buf_addr;
  logic          buf_empty;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic          de, hsync, vsync, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic          re_c;
  logic [AW-1:0] a_c;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .ADDR_W(AW), .H_ACTIVE(4), .V_ACTIVE(3),
    .H_FP(1), .H_SW(1), .H_BP(1), .V_FP(1), .V_SW(1), .V_BP(1)
  ) dut (
    .clk(clk), .reset(reset), .buf_full(buf_full),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .buf_re(buf_re), .buf_addr(buf_addr), .buf_empty(buf_empty),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
  );

  typedef struct {
    logic rst;
    logic full;
    logic e_empty;
    logic e_re;
    logic e_de;
    logic e_hs;
    logic e_vs;
    int   e_addr;
    int   e_pix;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int step, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  // One clock; the buffer model answers a read one clock later, 8'hFF otherwise.
  task automatic tick();
    re_c = buf_re;
    a_c  = buf_addr;
    @(posedge clk);
    #1;
    if (re_c) begin
      r_in = a_c[7:0];
      g_in = a_c[7:0] + 8'h40;
      b_in = a_c[7:0] + 8'h80;
    end else begin
      r_in = 8'hFF;
      g_in = 8'hFF;
      b_in = 8'hFF;
    end
    #1;
  endtask

  // Number of pixels read before scan clock kk (kk = h + 7*v).
  function automatic int cnt(input int kk);
    int h, v;
    if (kk < 0) return 0;
    h = kk % 7;
    v = kk / 7;
    if (v >= 3) return 12;
    return v * 4 + ((h < 4) ? h : 4);
  endfunction

  task automatic check_reset_vals(input int step);
    chk("rst_buf_empty", step, int'(buf_empty), 1);
    chk("rst_buf_re", step, int'(buf_re), 0);
    chk("rst_buf_addr", step, int'(buf_addr), 0);
    chk("rst_de", step, int'(de), 0);
    chk("rst_hsync", step, int'(hsync), 1);
    chk("rst_vsync", step, int'(vsync), 1);
    chk("rst_frame_done", step, int'(frame_done), 0);
    chk("rst_pix", step, int'({pix_r, pix_g, pix_b}), 0);
  endtask

  // Raises buf_full (entry on the first edge) and checks every clock to IDLE.
  task automatic run_frame(input int tag);
    int  h, v, kp, e_re, e_addr, e_de, e_hs, e_vs, e_empty, e_fd, e_r;
    buf_full = 1'b1;
    for (int k = 0; k <= 43; k++) begin
      tick();
      h  = k % 7;
      v  = k / 7;
      kp = k - 1;
      e_re    = (k <= 41 && h < 4 && v < 3) ? 1 : 0;
      e_addr  = (k <= 41) ? cnt(k) : ((k == 42) ? 12 : 0);
      e_empty = (k <= 41) ? 0 : 1;
      e_fd    = (k == 42) ? 1 : 0;
      e_de    = (kp >= 0 && kp <= 41 && (kp % 7) < 4 && (kp / 7) < 3) ? 1 : 0;
      e_hs    = (kp >= 0 && kp <= 41 && (kp % 7) == 5) ? 0 : 1;
      e_vs    = (kp >= 0 && kp <= 41 && (kp / 7) == 4) ? 0 : 1;
      e_r     = e_de ? cnt(kp) : 0;
      chk("buf_re", tag * 100 + k, int'(buf_re), e_re);
      chk("buf_addr", tag * 100 + k, int'(buf_addr), e_addr);
      chk("buf_empty", tag * 100 + k, int'(buf_empty), e_empty);
      chk("frame_done", tag * 100 + k, int'(frame_done), e_fd);
      chk("de", tag * 100 + k, int'(de), e_de);
      chk("hsync", tag * 100 + k, int'(hsync), e_hs);
      chk("vsync", tag * 100 + k, int'(vsync), e_vs);
      chk("pix_r", tag * 100 + k, int'(pix_r), e_r);
      chk("pix_g", tag * 100 + k, int'(pix_g), e_de ? ((e_r + 8'h40) & 8'hFF) : 0);
      chk("pix_b", tag * 100 + k, int'(pix_b), e_de ? ((e_r + 8'h80) & 8'hFF) : 0);
    end
  endtask

  initial begin
    bit found;
    reset    = 1'b1;
    buf_full = 1'b0;
    r_in     = 8'hFF;
    g_in     = 8'hFF;
    b_in     = 8'hFF;
    #1 reset = 1'b0;

    // rst full | empty re de hs vs | addr pix
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};

    for (int i = 0; i < 8; i++) begin
      reset    = vecs[i].rst;
      buf_full = vecs[i].full;
      tick();
      chk("vec_buf_empty", i, int'(buf_empty), int'(vecs[i].e_empty));
      chk("vec_buf_re", i, int'(buf_re), int'(vecs[i].e_re));
      chk("vec_de", i, int'(de), int'(vecs[i].e_de));
      chk("vec_hsync", i, int'(hsync), int'(vecs[i].e_hs));
      chk("vec_vsync", i, int'(vsync), int'(vecs[i].e_vs));
      chk("vec_buf_addr", i, int'(buf_addr), vecs[i].e_addr);
      chk("vec_pix_r", i, int'(pix_r), vecs[i].e_pix);
    end

    // Release reset with buf_full low: stays idle, then a full frame.
    reset    = 1'b1;
    buf_full = 1'b0;
    tick();
    chk("idle_buf_empty", 900, int'(buf_empty), 1);
    chk("idle_buf_re", 900, int'(buf_re), 0);
    run_frame(1);

    // buf_full still high after the frame: no rescan.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("norescan_buf_empty", 910 + i, int'(buf_empty), 1);
      chk("norescan_buf_re", 910 + i, int'(buf_re), 0);
      chk("norescan_de", 910 + i, int'(de), 0);
    end
    buf_full = 1'b0;
    tick();
    run_frame(2);

    // Reset in the middle of a frame, released with buf_full held high.
    buf_full = 1'b0;
    tick();
    buf_full = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (buf_addr == AW'(5)) found = 1'b1;
    end
    chk("reach_addr5", 920, int'(found), 1);
    #1 reset = 1'b0;
    #1;
    check_reset_vals(921);
    @(negedge clk);
    reset = 1'b1;
    run_frame(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
